// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle control unit: opcodes, FSM states,
// ALU/writeback select codes and status-register bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_LOD    = 4'h3;
    localparam logic [3:0] OP_STR    = 4'h4;
    localparam logic [3:0] OP_SWP    = 4'h5;
    localparam logic [3:0] OP_BRA    = 4'h6;
    localparam logic [3:0] OP_BRR    = 4'h7;
    localparam logic [3:0] OP_BNE    = 4'h8;
    localparam logic [3:0] OP_BNR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_WB2,
        ST_HALT
    } state_t;

    localparam logic [1:0] ALU_ARITH = 2'd0;
    localparam logic [1:0] ALU_LOGIC = 2'd1;
    localparam logic [1:0] ALU_PASS  = 2'd2;
    localparam logic [1:0] ALU_RSVD  = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_DM  = 2'd1;
    localparam logic [1:0] WB_RSA = 2'd2;
    localparam logic [1:0] WB_RSB = 2'd3;

    // statreg layout is {C,V,N,Z}
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;
    localparam int STAT_C = 3;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE) || (op == OP_BNR);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation: BRA/BRR take on any masked status bit set,
// BNE/BNR take when no masked bit is set. A zero mask therefore never/always takes.
module sisc_br_cond
    import sisc_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int MM_W = 4
) (
    input  logic [MM_W-1:0] stat,
    input  logic [MM_W-1:0] mm,
    input  logic [OP_W-1:0] opcode,
    output logic            taken
);

    logic [3:0] op;
    logic       hit;

    assign op  = 4'(opcode);
    assign hit = |(stat & mm);

    always_comb begin
        taken = 1'b0;
        if ((op == OP_BRA) || (op == OP_BRR)) begin
            taken = hit;
        end else if ((op == OP_BNE) || (op == OP_BNR)) begin
            taken = !hit;
        end
    end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle SISC control unit: fetch/decode/exec/mem/writeback sequencing with
// IM/DM handshakes, branch resolution, and cycle/retired-instruction counters.
module sisc_mc_ctrl
    import sisc_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int MM_W    = 4,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic [OP_W-1:0]    opcode,
    input  logic [MM_W-1:0]    mm,
    input  logic [MM_W-1:0]    stat,
    input  logic               im_rdy,
    input  logic               dm_rdy,
    output logic               im_req,
    output logic               dm_req,
    output logic               rf_we,
    output logic               dm_we,
    output logic               ir_load,
    output logic               pc_write,
    output logic               pc_rst,
    output logic               pc_sel,
    output logic               br_sel,
    output logic               rb_sel,
    output logic               mm_sel,
    output logic               rw_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         wb_sel,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retire_cnt
);

    state_t     state, state_next;
    logic [3:0] op;
    logic [1:0] alu_code;
    logic       taken;
    logic       retire;

    assign op = 4'(opcode);

    sisc_br_cond #(
        .OP_W (OP_W),
        .MM_W (MM_W)
    ) u_br_cond (
        .stat   (stat),
        .mm     (mm),
        .opcode (opcode),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != ST_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        im_req     = 1'b0;
        dm_req     = 1'b0;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_rst     = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        rb_sel     = 1'b0;
        mm_sel     = 1'b0;
        rw_sel     = 1'b0;
        alu_code   = ALU_ARITH;
        wb_sel     = WB_ALU;
        halted     = 1'b0;
        retire     = 1'b0;

        case (state)
            ST_RESET: begin
                pc_rst     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_rdy) begin
                    ir_load    = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // NOP and undefined opcodes skip EXEC and simply retire through WB
                if (op == OP_HLT) begin
                    state_next = ST_HALT;
                end else if ((op >= OP_ALU_RR) && (op <= OP_BNR)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_EXEC: begin
                alu_code = (op == OP_ALU_RI) ? ALU_PASS : ALU_ARITH;
                rb_sel   = (op == OP_STR) || (op == OP_SWP);
                mm_sel   = is_mem(op) && (mm == '0);
                if (is_branch(op)) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                    if (taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = (op == OP_BRA) || (op == OP_BNE);
                    end
                end else if (is_mem(op)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                if (dm_rdy) begin
                    dm_we      = (op == OP_STR);
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                if ((op == OP_ALU_RR) || (op == OP_ALU_RI)) begin
                    rf_we  = 1'b1;
                    wb_sel = WB_ALU;
                end else if (op == OP_LOD) begin
                    rf_we  = 1'b1;
                    wb_sel = WB_DM;
                end
                // SWP needs a second write port cycle; it retires on leaving WB2
                if (op == OP_SWP) begin
                    rf_we      = 1'b1;
                    wb_sel     = WB_RSB;
                    state_next = ST_WB2;
                end else begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_WB2: begin
                rf_we      = 1'b1;
                wb_sel     = WB_RSA;
                rw_sel     = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase

        alu_op = ALUOP_W'(alu_code);
    end

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Self-checking bench for sisc_mc_ctrl: per-instruction expected output traces
// built from the instruction rules, checked every cycle, plus literal spot checks.
module tb_sisc_mc_ctrl;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] RR  = 4'h1;
    localparam logic [3:0] RI  = 4'h2;
    localparam logic [3:0] LOD = 4'h3;
    localparam logic [3:0] STR = 4'h4;
    localparam logic [3:0] SWP = 4'h5;
    localparam logic [3:0] BRA = 4'h6;
    localparam logic [3:0] BRR = 4'h7;
    localparam logic [3:0] BNE = 4'h8;
    localparam logic [3:0] BNR = 4'h9;
    localparam logic [3:0] HLT = 4'hF;

    typedef struct packed {
        logic       im_req;
        logic       dm_req;
        logic       rf_we;
        logic       dm_we;
        logic       ir_load;
        logic       pc_write;
        logic       pc_rst;
        logic       pc_sel;
        logic       br_sel;
        logic       rb_sel;
        logic       mm_sel;
        logic       rw_sel;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       halted;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic [3:0] mm = 4'h0;
    logic [3:0] stat = 4'h0;
    logic       im_rdy = 1'b0;
    logic       dm_rdy = 1'b0;
    logic       im_req, dm_req, rf_we, dm_we, ir_load, pc_write, pc_rst;
    logic       pc_sel, br_sel, rb_sel, mm_sel, rw_sel, halted;
    logic [1:0] alu_op, wb_sel;
    logic [3:0] cycle_cnt, retire_cnt;

    int         n_pass = 0;
    int         n_total = 0;
    ctl_t       exp_ctl = '0;
    ctl_t       act_ctl;
    logic [3:0] m_cyc = 4'd0;
    logic [3:0] m_ret = 4'd0;
    logic       retire_pend = 1'b0;
    logic       chk_en = 1'b0;
    logic [3:0] cur_op = 4'h0;
    logic [3:0] cur_mm = 4'h0;
    logic [3:0] cur_stat = 4'h0;
    string      cur_tag = "reset";

    sisc_mc_ctrl #(
        .OP_W    (4),
        .MM_W    (4),
        .ALUOP_W (2),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .opcode     (opcode),
        .mm         (mm),
        .stat       (stat),
        .im_rdy     (im_rdy),
        .dm_rdy     (dm_rdy),
        .im_req     (im_req),
        .dm_req     (dm_req),
        .rf_we      (rf_we),
        .dm_we      (dm_we),
        .ir_load    (ir_load),
        .pc_write   (pc_write),
        .pc_rst     (pc_rst),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .rb_sel     (rb_sel),
        .mm_sel     (mm_sel),
        .rw_sel     (rw_sel),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Every checked cycle: strobes against the instruction trace, counters against the tally
    always @(negedge clk) begin
        if (chk_en) begin
            act_ctl = {im_req, dm_req, rf_we, dm_we, ir_load, pc_write, pc_rst, pc_sel,
                       br_sel, rb_sel, mm_sel, rw_sel, alu_op, wb_sel, halted};
            n_total++;
            if (act_ctl !== exp_ctl) begin
                $display("[TB] FAIL ctl %s t=%0t actual=%05h required=%05h",
                         cur_tag, $time, act_ctl, exp_ctl);
            end else begin
                n_pass++;
            end
            n_total++;
            if ({cycle_cnt, retire_cnt} !== {m_cyc, m_ret}) begin
                $display("[TB] FAIL cnt %s t=%0t actual cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                         cur_tag, $time, cycle_cnt, retire_cnt, m_cyc, m_ret);
            end else begin
                n_pass++;
            end
        end
    end

    // One clock cycle: update counter tally from the cycle just ended, then drive this cycle
    task automatic apply_stimulus(input logic rst, input logic imr, input logic dmr,
                                  input ctl_t e, input logic last, input logic chk);
        logic prev_rst, prev_halt, prev_last;
        prev_rst  = rst_f;
        prev_halt = exp_ctl.halted;
        prev_last = retire_pend;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            m_cyc = 4'd0;
            m_ret = 4'd0;
        end else begin
            if (!prev_halt) m_cyc = m_cyc + 4'd1;
            if (prev_last)  m_ret = m_ret + 4'd1;
        end
        rst_f       = rst;
        im_rdy      = imr;
        dm_rdy      = dmr;
        opcode      = cur_op;
        mm          = cur_mm;
        stat        = cur_stat;
        exp_ctl     = e;
        retire_pend = last;
        chk_en      = chk;
    endtask

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] req);
        n_total++;
        if (act !== req) begin
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // Expected per-cycle trace of one instruction, derived from its opcode and handshake waits
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] st, input int imw, input int dmw, input logic tie);
        ctl_t e;
        logic cond, taken, is_br, is_nop;
        cur_tag  = tag;
        cur_op   = op;
        cur_mm   = m;
        cur_stat = st;
        for (int i = 0; i < imw; i++) begin
            e = '0; e.im_req = 1'b1;
            apply_stimulus(1'b0, 1'b0, tie, e, 1'b0, 1'b1);
        end
        e = '0; e.im_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
        apply_stimulus(1'b0, 1'b1, tie, e, 1'b0, 1'b1);
        is_nop = !(op >= RR && op <= BNR) && (op != HLT);
        e = '0;
        apply_stimulus(1'b0, tie, tie, e, 1'b0, 1'b1);
        if (op == HLT) return;
        if (is_nop) begin
            apply_stimulus(1'b0, tie, tie, e, 1'b1, 1'b1);
            return;
        end
        e.alu_op = (op == RI) ? 2'd2 : 2'd0;
        e.rb_sel = (op == STR) || (op == SWP);
        e.mm_sel = ((op == LOD) || (op == STR)) && (m == 4'h0);
        is_br = (op == BRA) || (op == BRR) || (op == BNE) || (op == BNR);
        if (is_br) begin
            cond  = (st & m) != 4'h0;
            taken = ((op == BRA) || (op == BRR)) ? cond : !cond;
            e.pc_write = taken;
            e.pc_sel   = taken;
            e.br_sel   = taken && ((op == BRA) || (op == BNE));
            apply_stimulus(1'b0, tie, tie, e, 1'b1, 1'b1);
            return;
        end
        apply_stimulus(1'b0, tie, tie, e, 1'b0, 1'b1);
        if ((op == LOD) || (op == STR)) begin
            for (int i = 0; i < dmw; i++) begin
                e = '0; e.dm_req = 1'b1;
                apply_stimulus(1'b0, tie, 1'b0, e, 1'b0, 1'b1);
            end
            e = '0; e.dm_req = 1'b1; e.dm_we = (op == STR);
            apply_stimulus(1'b0, tie, 1'b1, e, 1'b0, 1'b1);
        end
        e = '0;
        if (op == SWP) begin
            e.rf_we = 1'b1; e.wb_sel = 2'd3; e.rw_sel = 1'b0;
            apply_stimulus(1'b0, tie, tie, e, 1'b0, 1'b1);
            e.wb_sel = 2'd2; e.rw_sel = 1'b1;
        end else if (op == LOD) begin
            e.rf_we = 1'b1; e.wb_sel = 2'd1;
        end else if ((op == RR) || (op == RI)) begin
            e.rf_we = 1'b1; e.wb_sel = 2'd0;
        end
        apply_stimulus(1'b0, tie, tie, e, 1'b1, 1'b1);
    endtask

    task automatic fetch_wait();
        ctl_t e;
        e = '0; e.im_req = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, e, 1'b0, 1'b1);
    endtask

    initial begin
        ctl_t e;
        e = '0;
        apply_stimulus(1'b1, 1'b0, 1'b0, e, 1'b0, 1'b0);
        e.pc_rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, e, 1'b0, 1'b1);

        // reset while FETCH is waiting on im_rdy
        cur_tag = "mid_fetch_reset";
        cur_op  = RR;
        fetch_wait();
        fetch_wait();
        e = '0; e.im_req = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, e, 1'b0, 1'b1);
        e = '0; e.pc_rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, e, 1'b0, 1'b1);
        #3;
        check_output("rst_im_req", 4'(im_req), 4'd0);
        check_output("rst_pc_rst", 4'(pc_rst), 4'd1);
        check_output("rst_cycle_cnt", cycle_cnt, 4'd0);
        check_output("rst_retire_cnt", retire_cnt, 4'd0);

        run_instr("alu_rr", RR, 4'h0, 4'h0, 0, 0, 1'b1);
        fetch_wait();
        #3;
        check_output("rr_cycle_cnt", cycle_cnt, 4'd5);
        check_output("rr_retire_cnt", retire_cnt, 4'd1);

        run_instr("alu_ri", RI, 4'h3, 4'h0, 1, 0, 1'b0);
        run_instr("lod_abs", LOD, 4'h0, 4'h0, 1, 3, 1'b0);
        run_instr("str_rel", STR, 4'h3, 4'h0, 0, 2, 1'b1);
        run_instr("lod_rel", LOD, 4'h5, 4'h0, 0, 0, 1'b1);
        run_instr("swp", SWP, 4'h0, 4'h0, 0, 0, 1'b0);
        run_instr("bne_not", BNE, 4'h1, 4'h1, 0, 0, 1'b0);
        run_instr("bne_taken", BNE, 4'h1, 4'h0, 0, 0, 1'b0);
        run_instr("brr_taken", BRR, 4'h2, 4'h2, 0, 0, 1'b1);
        run_instr("bra_mm0", BRA, 4'h0, 4'hF, 0, 0, 1'b0);
        run_instr("bra_taken", BRA, 4'hC, 4'h8, 0, 0, 1'b0);
        run_instr("bnr_mm0", BNR, 4'h0, 4'hF, 0, 0, 1'b0);
        run_instr("undef_c", 4'hC, 4'h7, 4'h0, 0, 0, 1'b1);
        run_instr("nop", NOP, 4'h0, 4'h0, 1, 0, 1'b0);

        // halt: absorbing, counters frozen, requests ignored until reset
        run_instr("hlt", HLT, 4'h0, 4'h0, 0, 0, 1'b0);
        cur_tag = "halted";
        for (int i = 0; i < 20; i++) begin
            e = '0; e.halted = 1'b1;
            apply_stimulus(1'b0, 1'b1, 1'b1, e, 1'b0, 1'b1);
        end
        #3;
        check_output("halt_halted", 4'(halted), 4'd1);
        check_output("halt_im_req", 4'(im_req), 4'd0);
        e = '0; e.halted = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, e, 1'b0, 1'b1);
        e = '0; e.pc_rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, e, 1'b0, 1'b1);

        // 16 retirements wrap the 4-bit retire counter
        for (int i = 0; i < 16; i++) begin
            run_instr("nop_wrap", NOP, 4'h0, 4'h0, 0, 0, 1'b1);
        end
        cur_tag = "post_wrap";
        fetch_wait();
        #3;
        check_output("wrap_retire_cnt", retire_cnt, 4'd0);
        check_output("wrap_cycle_cnt", cycle_cnt, 4'd1);
        check_output("wrap_halted", 4'(halted), 4'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
